// File: rtl/debug_ocimem_arbiter.sv
// debug_ocimem_arbiter
// Shares the single-port OCI debug RAM between the JTAG debug-slave command
// path (one-cycle pulses, never stalled) and the CPU-side Avalon debug-slave
// port (stalled with waitrequest). Owns the JTAG auto-incrementing address
// pointer, the MonDReg capture register and the monitor_ready strobe.
module debug_ocimem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  // JTAG command path
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_wr,
  input  logic              jtag_rd,
  input  logic [31:0]       jtag_wdata,
  output logic [31:0]       mon_dreg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  // CPU Avalon debug slave
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  // OCI RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // The read-wait states assume data one cycle after the address.
  if (RAM_RD_LAT != 1) begin : g_rd_lat_check
    $error("debug_ocimem_arbiter: only RAM_RD_LAT == 1 is supported");
  end

  typedef enum logic [2:0] {
    IDLE,
    J_WR,
    J_RD,
    J_RDW,
    C_WR,
    C_RD,
    C_RDW
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                pend_valid_q, pend_valid_d;
  logic                pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [31:0]         pend_data_q, pend_data_d;
  logic [31:0]         mon_dreg_q, mon_dreg_d;
  logic                mon_ready_q, mon_ready_d;
  logic                overrun_q, overrun_d;

  logic                jtag_cmd;
  logic                jtag_accept;
  logic                jtag_lost;
  logic [ADDR_W-1:0]   ptr_base;
  logic                pend_clr;

  // JTAG front end: pointer update, single-entry pending buffer, overrun flag
  always_comb begin
    jtag_cmd    = jtag_wr | jtag_rd;
    // An address load in the same cycle as an access is applied first.
    ptr_base    = jtag_addr_load ? jtag_addr : ptr_q;
    jtag_accept = jtag_cmd & ~pend_valid_q;
    // Lost: buffer already occupied, or a read colliding with a write.
    jtag_lost   = (jtag_cmd & pend_valid_q) | (jtag_wr & jtag_rd);

    ptr_d = ptr_q;
    if (jtag_addr_load) begin
      ptr_d = jtag_addr;
    end
    if (jtag_accept) begin
      ptr_d = ptr_base + PTR_ONE;
    end

    overrun_d = overrun_q;
    if (jtag_addr_load) begin
      overrun_d = 1'b0;
    end
    if (jtag_lost) begin
      overrun_d = 1'b1;
    end

    pend_valid_d = pend_valid_q;
    pend_wr_d    = pend_wr_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (pend_clr) begin
      pend_valid_d = 1'b0;
    end
    if (jtag_accept) begin
      pend_valid_d = 1'b1;
      pend_wr_d    = jtag_wr;
      pend_addr_d  = ptr_base;
      pend_data_d  = jtag_wdata;
    end
  end

  // Arbitration FSM: next state and RAM / Avalon outputs decoded from state
  always_comb begin
    state_d         = state_q;
    pend_clr        = 1'b0;
    ram_addr        = '0;
    ram_wren        = 1'b0;
    ram_byteen      = '0;
    ram_wdata       = '0;
    cpu_waitrequest = 1'b1;
    cpu_readdata    = '0;
    mon_dreg_d      = mon_dreg_q;
    mon_ready_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          state_d = pend_wr_q ? J_WR : J_RD;
        end else if (jtag_cmd) begin
          // A JTAG pulse landing in the buffer this cycle outranks a CPU
          // request seen in the same cycle; serve it from the buffer next.
          state_d = IDLE;
        end else if (cpu_write) begin
          state_d = C_WR;
        end else if (cpu_read) begin
          state_d = C_RD;
        end
      end
      J_WR: begin
        ram_addr    = pend_addr_q;
        ram_wdata   = pend_data_q;
        ram_byteen  = 4'hF;
        ram_wren    = 1'b1;
        pend_clr    = 1'b1;
        mon_ready_d = 1'b1;
        state_d     = IDLE;
      end
      J_RD: begin
        ram_addr = pend_addr_q;
        pend_clr = 1'b1;
        state_d  = J_RDW;
      end
      J_RDW: begin
        mon_dreg_d  = ram_rdata;
        mon_ready_d = 1'b1;
        state_d     = IDLE;
      end
      C_WR: begin
        ram_addr        = cpu_address;
        ram_wdata       = cpu_writedata;
        ram_byteen      = cpu_byteenable;
        ram_wren        = 1'b1;
        cpu_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      C_RD: begin
        ram_addr = cpu_address;
        state_d  = C_RDW;
      end
      C_RDW: begin
        cpu_readdata    = ram_rdata;
        cpu_waitrequest = 1'b0;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and register file, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      mon_dreg_q   <= '0;
      mon_ready_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_wr_q    <= pend_wr_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      mon_dreg_q   <= mon_dreg_d;
      mon_ready_q  <= mon_ready_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mon_dreg      = mon_dreg_q;
  assign monitor_ready = mon_ready_q;
  assign jtag_overrun  = overrun_q;

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Self-checking bench for debug_ocimem_arbiter with a behavioural OCI RAM
// and a word-level reference model of pointer, memory, MonDReg and overrun.
module tb_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jtag_addr_load = 1'b0;
  logic [7:0]  jtag_addr = '0;
  logic        jtag_wr = 1'b0;
  logic        jtag_rd = 1'b0;
  logic [31:0] jtag_wdata = '0;
  logic [31:0] mon_dreg;
  logic        monitor_ready;
  logic        jtag_overrun;
  logic [7:0]  cpu_address = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_writedata = '0;
  logic [3:0]  cpu_byteenable = '0;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  debug_ocimem_arbiter #(.ADDR_W(8), .RAM_RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .jtag_addr_load(jtag_addr_load), .jtag_addr(jtag_addr),
    .jtag_wr(jtag_wr), .jtag_rd(jtag_rd), .jtag_wdata(jtag_wdata),
    .mon_dreg(mon_dreg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural single-port RAM, one-cycle read latency, byte-lane writes
  logic [31:0] ram [256];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else begin
      if (ram_wren)
        for (int b = 0; b < 4; b++)
          if (ram_byteen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [7:0]  ptr_m;
  logic        ovr_m;
  logic [31:0] mon_m;
  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    ptr_m = 8'h00;
    ovr_m = 1'b0;
    mon_m = 32'h0;
  endtask

  // One JTAG command (any mix of load/wr/rd), checked over its full latency
  task automatic jtag_cmd(input logic ld, input logic [7:0] a, input logic wr,
                          input logic rd, input logic [31:0] d);
    logic [7:0]  acc_addr;
    logic        acc;
    logic [31:0] exp_rd;
    acc_addr = ld ? a : ptr_m;
    acc      = wr | rd;
    exp_rd   = ref_mem[acc_addr];
    if (ld) ovr_m = 1'b0;
    if (wr && rd) ovr_m = 1'b1;
    if (acc) ptr_m = acc_addr + 8'd1;
    else if (ld) ptr_m = a;
    @(posedge clk); #1;
    jtag_addr_load = ld; jtag_addr = a; jtag_wr = wr; jtag_rd = rd; jtag_wdata = d;
    @(posedge clk); #1;
    jtag_addr_load = 0; jtag_wr = 0; jtag_rd = 0;
    @(negedge clk);
    total++;
    if ({monitor_ready, ram_wren} !== 2'b00) begin
      bad++; $display("FAIL jtag_t0_quiet: got ready/wren=%b want 00", {monitor_ready, ram_wren});
    end
    @(negedge clk);
    total++;
    if (acc && wr) begin
      if ({ram_wren, ram_addr, ram_byteen, ram_wdata} !== {1'b1, acc_addr, 4'hF, d}) begin
        bad++; $display("FAIL jtag_wr_access: got wren=%b addr=%h be=%h data=%h want 1 %h f %h",
                        ram_wren, ram_addr, ram_byteen, ram_wdata, acc_addr, d);
      end
      ref_mem[acc_addr] = d;
    end else if (acc) begin
      if ({ram_wren, ram_addr} !== {1'b0, acc_addr}) begin
        bad++; $display("FAIL jtag_rd_access: got wren=%b addr=%h want 0 %h", ram_wren, ram_addr, acc_addr);
      end
    end else begin
      if (ram_wren !== 1'b0) begin
        bad++; $display("FAIL jtag_load_only: got wren=%b want 0", ram_wren);
      end
    end
    @(negedge clk);
    total++;
    if (monitor_ready !== (acc && wr)) begin
      bad++; $display("FAIL jtag_ready_t2: got %b want %b", monitor_ready, acc && wr);
    end
    @(negedge clk);
    if (acc && !wr) mon_m = exp_rd;
    total++;
    if (monitor_ready !== (acc && !wr)) begin
      bad++; $display("FAIL jtag_ready_t3: got %b want %b", monitor_ready, acc && !wr);
    end
    total++;
    if (mon_dreg !== mon_m) begin
      bad++; $display("FAIL jtag_mon_dreg: got %h want %h", mon_dreg, mon_m);
    end
    total++;
    if (jtag_overrun !== ovr_m) begin
      bad++; $display("FAIL jtag_overrun: got %b want %b", jtag_overrun, ovr_m);
    end
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    cpu_write = 1; cpu_address = a; cpu_writedata = d; cpu_byteenable = be;
    @(negedge clk);
    total++;
    if (cpu_waitrequest !== 1'b1) begin
      bad++; $display("FAIL cpu_wr_wait1: got %b want 1", cpu_waitrequest);
    end
    @(negedge clk);
    total++;
    if ({cpu_waitrequest, ram_wren, ram_addr, ram_byteen, ram_wdata} !== {1'b0, 1'b1, a, be, d}) begin
      bad++; $display("FAIL cpu_wr_access: got wait=%b wren=%b addr=%h be=%h data=%h want 0 1 %h %h %h",
                      cpu_waitrequest, ram_wren, ram_addr, ram_byteen, ram_wdata, a, be, d);
    end
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); #1;
    cpu_write = 0;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    @(posedge clk); #1;
    cpu_read = 1; cpu_address = a;
    @(negedge clk);
    total++;
    if (cpu_waitrequest !== 1'b1) begin
      bad++; $display("FAIL cpu_rd_wait1: got %b want 1", cpu_waitrequest);
    end
    @(negedge clk);
    total++;
    if ({cpu_waitrequest, ram_wren, ram_addr} !== {1'b1, 1'b0, a}) begin
      bad++; $display("FAIL cpu_rd_addr: got wait=%b wren=%b addr=%h want 1 0 %h",
                      cpu_waitrequest, ram_wren, ram_addr, a);
    end
    @(negedge clk);
    total++;
    if ({cpu_waitrequest, cpu_readdata} !== {1'b0, ref_mem[a]}) begin
      bad++; $display("FAIL cpu_rd_data: got wait=%b data=%h want 0 %h", cpu_waitrequest, cpu_readdata, ref_mem[a]);
    end
    @(posedge clk); #1;
    cpu_read = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mon_dreg, monitor_ready, jtag_overrun} !== 34'h0) begin
      bad++; $display("FAIL reset_jtag_outs: got mon=%h rdy=%b ovr=%b want 0", mon_dreg, monitor_ready, jtag_overrun);
    end
    total++;
    if ({cpu_waitrequest, cpu_readdata} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL reset_cpu_outs: got wait=%b data=%h want 1 0", cpu_waitrequest, cpu_readdata);
    end
    total++;
    if ({ram_wren, ram_addr, ram_byteen, ram_wdata} !== 45'h0) begin
      bad++; $display("FAIL reset_ram_outs: got wren=%b addr=%h be=%h data=%h want 0",
                      ram_wren, ram_addr, ram_byteen, ram_wdata);
    end
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_jtag_write_read();
    jtag_cmd(1, 8'h10, 0, 0, 32'h0);
    jtag_cmd(0, 8'h00, 1, 0, 32'hDEADBEEF);
    jtag_cmd(0, 8'h00, 1, 0, 32'h12345678);
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);           // pointer must now be 0x12
    jtag_cmd(1, 8'h10, 0, 0, 32'h0);
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);
    total++;
    if (mon_dreg !== 32'hDEADBEEF) begin
      bad++; $display("FAIL jtag_rd_first: got %h want deadbeef", mon_dreg);
    end
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);
    total++;
    if (mon_dreg !== 32'h12345678) begin
      bad++; $display("FAIL jtag_rd_second: got %h want 12345678", mon_dreg);
    end
  endtask

  task automatic test_wrap();
    jtag_cmd(1, 8'hFF, 1, 0, 32'hCAFE00FF);
    jtag_cmd(0, 8'h00, 1, 0, 32'hCAFE0000);
    jtag_cmd(1, 8'hFF, 0, 1, 32'h0);
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);
  endtask

  task automatic test_contention();
    logic [31:0] d;
    d = $urandom;
    @(posedge clk); #1;
    cpu_read = 1; cpu_address = 8'h10;
    jtag_addr_load = 1; jtag_addr = 8'h10; jtag_wr = 1; jtag_wdata = d;
    ptr_m = 8'h11; ovr_m = 0;
    @(posedge clk); #1;
    jtag_addr_load = 0; jtag_wr = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        total++;
        if ({ram_wren, ram_addr, ram_byteen, ram_wdata} !== {1'b1, 8'h10, 4'hF, d}) begin
          bad++; $display("FAIL cont_jtag_first: got wren=%b addr=%h be=%h data=%h want 1 10 f %h",
                          ram_wren, ram_addr, ram_byteen, ram_wdata, d);
        end
        ref_mem[8'h10] = d;
      end
      if (k == 2) begin
        total++;
        if (monitor_ready !== 1'b1) begin
          bad++; $display("FAIL cont_ready: got %b want 1", monitor_ready);
        end
      end
      total++;
      if (k < 4) begin
        if (cpu_waitrequest !== 1'b1) begin
          bad++; $display("FAIL cont_wait_k%0d: got %b want 1", k, cpu_waitrequest);
        end
      end else begin
        if ({cpu_waitrequest, cpu_readdata} !== {1'b0, d}) begin
          bad++; $display("FAIL cont_readdata: got wait=%b data=%h want 0 %h", cpu_waitrequest, cpu_readdata, d);
        end
      end
    end
    @(posedge clk); #1;
    cpu_read = 0;
  endtask

  task automatic test_overrun();
    jtag_cmd(1, 8'h10, 0, 0, 32'h0);
    @(posedge clk); #1;
    jtag_rd = 1;
    @(posedge clk); #1;          // first pulse taken at this edge
    @(posedge clk); #1;          // second pulse dropped at this edge
    jtag_rd = 0;
    ptr_m = 8'h11; ovr_m = 1;
    @(negedge clk);
    total++;
    if ({ram_wren, ram_addr, jtag_overrun} !== {1'b0, 8'h10, 1'b1}) begin
      bad++; $display("FAIL ovr_access: got wren=%b addr=%h ovr=%b want 0 10 1", ram_wren, ram_addr, jtag_overrun);
    end
    @(negedge clk);
    @(negedge clk);
    mon_m = ref_mem[8'h10];
    total++;
    if ({monitor_ready, mon_dreg} !== {1'b1, mon_m}) begin
      bad++; $display("FAIL ovr_first_rd: got rdy=%b mon=%h want 1 %h", monitor_ready, mon_dreg, mon_m);
    end
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);   // reads 0x11, overrun stays set
    jtag_cmd(1, 8'h20, 0, 0, 32'h0);   // load clears overrun
  endtask

  task automatic test_wr_rd_together();
    jtag_cmd(1, 8'h40, 1, 1, 32'h0BADF00D);
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);
    jtag_cmd(1, 8'h40, 0, 1, 32'h0);
  endtask

  task automatic test_byteenable();
    cpu_wr(8'h30, 32'h0, 4'hF);
    cpu_wr(8'h30, 32'hAABBCCDD, 4'b0011);
    cpu_rd(8'h30);
    total++;
    if (cpu_readdata !== 32'h0) begin
      bad++; $display("FAIL be_idle_readdata: got %h want 0", cpu_readdata);
    end
    jtag_cmd(1, 8'h30, 0, 1, 32'h0);
    total++;
    if (mon_dreg !== 32'h0000CCDD) begin
      bad++; $display("FAIL be_merge: got %h want 0000ccdd", mon_dreg);
    end
  endtask

  task automatic test_random_jtag();
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFD, 8'hFF)) : 8'($urandom);
      d = $urandom;
      case ($urandom_range(0, 4))
        0: jtag_cmd(0, a, 1, 0, d);
        1: jtag_cmd(0, a, 0, 1, d);
        2: jtag_cmd(1, a, 1, 0, d);
        3: jtag_cmd(1, a, 0, 1, d);
        default: jtag_cmd(1, a, 0, 0, d);
      endcase
    end
  endtask

  task automatic test_random_cpu();
    for (int i = 0; i < 30; i++) begin
      logic [7:0] a;
      a = 8'h80 + 8'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: cpu_wr(a, $urandom, 4'($urandom));
        1: cpu_rd(a);
        default: jtag_cmd(1, a, 0, 1, 32'h0);
      endcase
    end
  endtask

  task automatic test_reset_mid_cpu_read();
    @(posedge clk); #1;
    cpu_read = 1; cpu_address = 8'h21;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({cpu_waitrequest, ram_addr} !== {1'b1, 8'h21}) begin
      bad++; $display("FAIL rst_crd_pre: got wait=%b addr=%h want 1 21", cpu_waitrequest, ram_addr);
    end
    #1 reset = 1;
    #1;
    total++;
    if ({cpu_waitrequest, ram_wren, ram_addr, cpu_readdata} !== {1'b1, 1'b0, 8'h00, 32'h0}) begin
      bad++; $display("FAIL rst_crd_abort: got wait=%b wren=%b addr=%h data=%h want 1 0 00 0",
                      cpu_waitrequest, ram_wren, ram_addr, cpu_readdata);
    end
    cpu_read = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    @(negedge clk);
    total++;
    if ({cpu_waitrequest, mon_dreg, jtag_overrun} !== {1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL rst_crd_post: got wait=%b mon=%h ovr=%b want 1 0 0", cpu_waitrequest, mon_dreg, jtag_overrun);
    end
    cpu_rd(8'h21);
  endtask

  task automatic test_reset_mid_jtag_write();
    @(posedge clk); #1;
    jtag_addr_load = 1; jtag_addr = 8'h50; jtag_wr = 1; jtag_wdata = ~ref_mem[8'h50];
    @(posedge clk); #1;
    jtag_addr_load = 0; jtag_wr = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({ram_wren, ram_addr} !== {1'b1, 8'h50}) begin
      bad++; $display("FAIL rst_jwr_pre: got wren=%b addr=%h want 1 50", ram_wren, ram_addr);
    end
    #1 reset = 1;
    #1;
    total++;
    if (ram_wren !== 1'b0) begin
      bad++; $display("FAIL rst_jwr_abort: got wren=%b want 0", ram_wren);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    cpu_rd(8'h50);                       // old contents survive
    jtag_cmd(0, 8'h00, 0, 1, 32'h0);     // pointer restarted at 0
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();
    test_reset();
    test_jtag_write_read();
    test_wrap();
    test_contention();
    test_overrun();
    test_wr_rd_together();
    test_byteenable();
    test_random_jtag();
    test_random_cpu();
    test_reset_mid_cpu_read();
    test_reset_mid_jtag_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/debug_ocimem_arbiter.md
Name: debug_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug memory (OCI RAM, 32-bit words) between two requesters:
  - the JTAG debug-slave command path, which issues clk-domain one-cycle action pulses and cannot be stalled;
  - the CPU-side Avalon debug-slave port, which is stallable via waitrequest.
- Sits between the debug-slave sysclk decoder and the OCI RAM.
- Owns the JTAG auto-incrementing address pointer, the MonDReg capture register and the monitor_ready strobe.

Parameters:
ADDR_W, 8, OCI RAM word-address width; pointer wraps modulo 2^ADDR_W.
RAM_RD_LAT, 1, OCI RAM read latency in cycles (fixed; only 1 is supported).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
jtag_addr_load  in  1  one-cycle pulse: load pointer from jtag_addr
jtag_addr  in  ADDR_W  JTAG start address
jtag_wr  in  1  one-cycle pulse: write jtag_wdata at pointer, then increment pointer
jtag_rd  in  1  one-cycle pulse: read at pointer, then increment pointer
jtag_wdata  in  32  JTAG write data
mon_dreg  out  32  last JTAG read data (MonDReg)
monitor_ready  out  1  one-cycle pulse: JTAG access completed
jtag_overrun  out  1  sticky: JTAG command lost
cpu_address  in  ADDR_W  Avalon word address
cpu_read  in  1  Avalon read
cpu_write  in  1  Avalon write
cpu_writedata  in  32  Avalon write data
cpu_byteenable  in  4  Avalon byte enables
cpu_waitrequest  out  1  Avalon stall
cpu_readdata  out  32  Avalon read data, valid when read and !waitrequest
ram_addr  out  ADDR_W  OCI RAM address
ram_wren  out  1  OCI RAM write enable
ram_byteen  out  4  OCI RAM byte enables
ram_wdata  out  32  OCI RAM write data
ram_rdata  in  32  OCI RAM read data, valid RAM_RD_LAT cycles after address

Behaviour:
- Reset values:
  - outputs: mon_dreg=0, monitor_ready=0, jtag_overrun=0, cpu_waitrequest=1, cpu_readdata=0, ram_wren=0, ram_addr=0, ram_byteen=0, ram_wdata=0;
  - internal: pointer=0, pending=empty, FSM=IDLE.
- Reset mid-operation aborts any access immediately, with no RAM write completing after reset asserts.
- JTAG pending buffer (one entry: op, address, data):
  - jtag_wr or jtag_rd captures {op, pointer, jtag_wdata} at the edge, then pointer <= pointer+1 (wraps 2^ADDR_W-1 -> 0).
  - jtag_addr_load in the same cycle as wr/rd: the load applies first, so the access uses jtag_addr and the pointer becomes jtag_addr+1.
  - jtag_wr and jtag_rd together: the write is captured, the read is dropped, jtag_overrun is set.
  - New wr/rd while pending is full: the command is dropped, the pointer is unchanged, jtag_overrun is set.
  - jtag_overrun clears only on jtag_addr_load, or on reset.
- FSM states: IDLE, J_WR, J_RD, J_RDW, C_WR, C_RD, C_RDW.
  - IDLE: pending valid -> J_WR or J_RD (JTAG has absolute priority). Otherwise cpu_write -> C_WR; otherwise cpu_read -> C_RD. If cpu_read and cpu_write are both high, the write is taken.
  - J_WR: ram_addr/wdata from pending, ram_wren=1, ram_byteen=4'hF; pending cleared; monitor_ready pulses the next cycle; -> IDLE.
  - J_RD: ram_addr from pending, ram_wren=0; pending cleared; -> J_RDW.
  - J_RDW: mon_dreg <= ram_rdata; monitor_ready=1 the following cycle (registered pulse); -> IDLE.
  - C_WR: ram_addr=cpu_address, ram_wdata=cpu_writedata, ram_byteen=cpu_byteenable, ram_wren=1; cpu_waitrequest=0 this cycle; -> IDLE.
  - C_RD: ram_addr=cpu_address; -> C_RDW.
  - C_RDW: cpu_readdata=ram_rdata, cpu_waitrequest=0 this cycle; -> IDLE.
- cpu_waitrequest is 1 in every state except C_WR and C_RDW.
- Latency, JTAG: pulse at edge t -> RAM access cycle t+1 if IDLE. Write: monitor_ready high in cycle t+2. Read: mon_dreg valid and monitor_ready high in cycle t+3.
- Latency, CPU uncontended: write completes in the 2nd cycle of assertion; read completes in the 3rd cycle.
- JTAG pulses arrive no faster than one per 4 cycles (TCK-derived), so a single-entry buffer with priority never loses commands in normal operation. CPU starvation is bounded by that rate.
- Byte enables apply only to CPU writes; JTAG writes are always full word.

Test Plan:
- Reset, then jtag_addr_load(jtag_addr=8'h10), jtag_wr(wdata=32'hDEADBEEF), jtag_wr(32'h12345678) -> RAM writes at 0x10 and 0x11, byteen=F; two monitor_ready pulses; pointer=0x12.
- jtag_addr_load(0x10), jtag_rd -> mon_dreg=32'hDEADBEEF exactly 3 cycles after the pulse with monitor_ready high that cycle; the next rd returns 32'h12345678.
- Pointer at 0xFF, jtag_wr -> write at 0xFF, next jtag_wr writes 0x00.
- cpu_read held at 0x10 while jtag_wr arrives the same cycle -> JTAG write first; cpu_waitrequest stays 1 until C_RDW; cpu_readdata equals the newly written value.
- Two jtag_rd pulses on consecutive cycles -> second dropped, jtag_overrun=1, pointer advanced once; jtag_addr_load clears overrun.
- CPU write byteenable=4'b0011, data 32'hAABBCCDD over 0 -> RAM word 32'h0000CCDD on readback. Assert reset during C_RD -> waitrequest=1, ram_wren=0, FSM=IDLE.
